// File: rtl/tone_buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tone_buffer_pkg : shared DMT frame constants and bank/reader state codes
// Revision: 1.0
// ---------------------------------------------------------------------------
package tone_buffer_pkg;

  localparam int NCARRIER = 256;
  localparam int CNUMW    = 8;
  localparam int CONSTW   = 15;

  localparam logic [CNUMW-1:0] LAST_CARRIER = CNUMW'(NCARRIER - 1);

  localparam logic [1:0] BANK_EMPTY   = 2'd0;
  localparam logic [1:0] BANK_FILLING = 2'd1;
  localparam logic [1:0] BANK_FULL    = 2'd2;
  localparam logic [1:0] BANK_READING = 2'd3;

  localparam logic [0:0] RD_IDLE   = 1'b0;
  localparam logic [0:0] RD_STREAM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/tone_buffer_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tone_bank : one per-carrier {x,y} store with written-map and async read
// Revision: 1.0
// ---------------------------------------------------------------------------
module tone_bank
  import tone_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [CNUMW-1:0]      i_waddr,
  input  logic [2*CONSTW-1:0]   i_wdata,
  input  logic                  i_clr,
  input  logic [CNUMW-1:0]      i_raddr,
  output logic [2*CONSTW-1:0]   o_rdata,
  output logic                  o_rwritten
);

  logic [2*CONSTW-1:0] r_mem [NCARRIER];
  logic [NCARRIER-1:0] r_map;

  // Storage needs no reset: unwritten entries are masked by the map.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_map <= '0;
    end else begin
      if (i_clr) r_map <= '0;
      if (i_we)  r_map[i_waddr] <= 1'b1;
    end
  end

  assign o_rdata    = r_mem[i_raddr];
  assign o_rwritten = r_map[i_raddr];

endmodule
`default_nettype wire

// File: rtl/tone_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tone_buffer : ping-pong DMT symbol buffer, streams carriers 0..N-1 to IFFT
// Revision: 1.0
// ---------------------------------------------------------------------------
module tone_buffer
  import tone_buffer_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     xy_ready_i,
  input  logic [CNUMW-1:0]         carrier_num_i,
  input  logic signed [CONSTW-1:0] x_i,
  input  logic signed [CONSTW-1:0] y_i,
  input  logic                     sym_done_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [CNUMW-1:0]         out_num_o,
  output logic signed [CONSTW-1:0] out_x_o,
  output logic signed [CONSTW-1:0] out_y_o,
  output logic                     out_last_o,
  output logic                     overflow_o
);

  logic                     r_wbank;
  logic [1:0]               r_bstate [2];
  logic [0:0]               r_rd_state;
  logic [CNUMW-1:0]         r_cnt;
  logic                     r_valid;
  logic [CNUMW-1:0]         r_num;
  logic signed [CONSTW-1:0] r_x;
  logic signed [CONSTW-1:0] r_y;
  logic                     r_last;
  logic                     r_ovf;

  logic                     w_rbank;
  logic                     w_in_ready;
  logic                     w_wr;
  logic                     w_done;
  logic                     w_hs;
  logic                     w_final;
  logic                     w_swap;
  logic [1:0]               w_we;
  logic [1:0]               w_clr;
  logic [2*CONSTW-1:0]      w_rdata [2];
  logic [1:0]               w_rwritten;
  logic [2*CONSTW-1:0]      w_sel_data;
  logic                     w_sel_hit;
  logic [1:0]               w_bnext [2];

  assign w_rbank    = ~r_wbank;
  assign w_in_ready = (r_bstate[r_wbank] != BANK_FULL);
  assign w_wr       = xy_ready_i & w_in_ready;
  assign w_done     = sym_done_i & w_in_ready;
  assign w_hs       = r_valid & out_ready_i;
  assign w_final    = w_hs & r_last;
  // Swapping on the final handshake itself gives a single idle beat between symbols.
  assign w_swap     = ((r_rd_state == RD_IDLE) | w_final) &
                      ((r_bstate[r_wbank] == BANK_FULL) | w_done);

  assign w_we       = w_wr   ? (r_wbank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr      = w_swap ? (r_wbank ? 2'b01 : 2'b10) : 2'b00;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tone_bank u_bank (
      .clk        (clk),
      .reset      (reset),
      .i_we       (w_we[b]),
      .i_waddr    (carrier_num_i),
      .i_wdata    ({x_i, y_i}),
      .i_clr      (w_clr[b]),
      .i_raddr    (r_cnt),
      .o_rdata    (w_rdata[b]),
      .o_rwritten (w_rwritten[b])
    );
  end

  assign w_sel_data = w_rdata[w_rbank];
  assign w_sel_hit  = w_rwritten[w_rbank];

  always_comb begin
    w_bnext[0] = r_bstate[0];
    w_bnext[1] = r_bstate[1];
    if (w_wr && (r_bstate[r_wbank] == BANK_EMPTY)) w_bnext[r_wbank] = BANK_FILLING;
    if (w_done)  w_bnext[r_wbank] = BANK_FULL;
    if (w_final) w_bnext[w_rbank] = BANK_EMPTY;
    if (w_swap) begin
      w_bnext[r_wbank] = BANK_READING;
      w_bnext[w_rbank] = BANK_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wbank     <= 1'b0;
      r_bstate[0] <= BANK_EMPTY;
      r_bstate[1] <= BANK_EMPTY;
      r_ovf       <= 1'b0;
    end else begin
      r_bstate <= w_bnext;
      if (w_swap) r_wbank <= ~r_wbank;
      if ((xy_ready_i | sym_done_i) & ~w_in_ready) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_state <= RD_IDLE;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_num      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_last     <= 1'b0;
    end else if (w_swap) begin
      r_rd_state <= RD_STREAM;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
    end else if (r_rd_state == RD_STREAM) begin
      if (w_final) begin
        r_rd_state <= RD_IDLE;
        r_valid    <= 1'b0;
        r_last     <= 1'b0;
      end else if (!r_valid || w_hs) begin
        r_valid <= 1'b1;
        r_num   <= r_cnt;
        r_x     <= w_sel_hit ? w_sel_data[2*CONSTW-1:CONSTW] : '0;
        r_y     <= w_sel_hit ? w_sel_data[CONSTW-1:0] : '0;
        r_last  <= (r_cnt == LAST_CARRIER);
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = r_valid;
  assign out_num_o   = r_num;
  assign out_x_o     = r_x;
  assign out_y_o     = r_y;
  assign out_last_o  = r_last;
  assign overflow_o  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_tone_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tone_buffer : scoreboard bench with a per-symbol array model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_tone_buffer;
  import tone_buffer_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              xy_ready_i = 1'b0;
  logic [CNUMW-1:0]  carrier_num_i = '0;
  logic [CONSTW-1:0] x_i = '0;
  logic [CONSTW-1:0] y_i = '0;
  logic              sym_done_i = 1'b0;
  logic              in_ready_o;
  logic              out_valid_o;
  logic              out_ready_i = 1'b1;
  logic [CNUMW-1:0]  out_num_o;
  logic [CONSTW-1:0] out_x_o;
  logic [CONSTW-1:0] out_y_o;
  logic              out_last_o;
  logic              overflow_o;

  tone_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .xy_ready_i    (xy_ready_i),
    .carrier_num_i (carrier_num_i),
    .x_i           (x_i),
    .y_i           (y_i),
    .sym_done_i    (sym_done_i),
    .in_ready_o    (in_ready_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_num_o     (out_num_o),
    .out_x_o       (out_x_o),
    .out_y_o       (out_y_o),
    .out_last_o    (out_last_o),
    .overflow_o    (overflow_o)
  );

  typedef struct {
    logic [CNUMW-1:0]  num;
    logic [CONSTW-1:0] x;
    logic [CONSTW-1:0] y;
    logic              last;
  } beat_t;

  beat_t             exp_q[$];
  int                tests = 0;
  int                fails = 0;
  int                beats = 0;
  time               t_last_hs = 0;
  bit                rnd_ready = 1'b0;
  logic [CONSTW-1:0] m_x [NCARRIER];
  logic [CONSTW-1:0] m_y [NCARRIER];
  bit                m_wr [NCARRIER];

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    out_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops one expected beat per handshake, checks stall stability.
  initial begin
    beat_t e;
    beat_t h;
    bit    held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          tests++;
          if (!out_valid_o || out_num_o !== h.num || out_x_o !== h.x ||
              out_y_o !== h.y || out_last_o !== h.last) begin
            fails++;
            $display("FAIL stall_hold: got v=%0b n=%0d x=%0h y=%0h l=%0b expected v=1 n=%0d x=%0h y=%0h l=%0b",
                     out_valid_o, out_num_o, out_x_o, out_y_o, out_last_o, h.num, h.x, h.y, h.last);
          end
        end
        held = 1'b0;
        if (out_valid_o && out_ready_i) begin
          beats++;
          if (out_last_o) t_last_hs = $time;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL beat_unexpected: got carrier %0d expected no beat", out_num_o);
          end else begin
            e = exp_q.pop_front();
            if (out_num_o !== e.num || out_x_o !== e.x || out_y_o !== e.y || out_last_o !== e.last) begin
              fails++;
              $display("FAIL beat: got n=%0d x=%0h y=%0h l=%0b expected n=%0d x=%0h y=%0h l=%0b",
                       out_num_o, out_x_o, out_y_o, out_last_o, e.num, e.x, e.y, e.last);
            end
          end
        end else if (out_valid_o) begin
          held   = 1'b1;
          h.num  = out_num_o;
          h.x    = out_x_o;
          h.y    = out_y_o;
          h.last = out_last_o;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready_o && n < 3000) begin
      step();
      n++;
    end
    if (!in_ready_o) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCARRIER; c++) m_wr[c] = 1'b0;
  endtask

  task automatic model_close();
    beat_t b;
    for (int c = 0; c < NCARRIER; c++) begin
      b.num  = CNUMW'(c);
      b.x    = m_wr[c] ? m_x[c] : '0;
      b.y    = m_wr[c] ? m_y[c] : '0;
      b.last = (c == NCARRIER - 1);
      exp_q.push_back(b);
    end
    model_clear();
  endtask

  task automatic drive_point(input int c, input logic [CONSTW-1:0] x, input logic [CONSTW-1:0] y);
    xy_ready_i    = 1'b1;
    carrier_num_i = CNUMW'(c);
    x_i           = x;
    y_i           = y;
    if (in_ready_o) begin
      m_x[c]  = x;
      m_y[c]  = y;
      m_wr[c] = 1'b1;
    end
  endtask

  task automatic do_write(input int c, input logic [CONSTW-1:0] x, input logic [CONSTW-1:0] y);
    wait_in_ready();
    drive_point(c, x, y);
    step();
    xy_ready_i = 1'b0;
  endtask

  task automatic do_close(input bit with_wr, input int c, input logic [CONSTW-1:0] x,
                          input logic [CONSTW-1:0] y);
    wait_in_ready();
    if (with_wr) drive_point(c, x, y);
    sym_done_i = 1'b1;
    if (in_ready_o) model_close();
    step();
    sym_done_i = 1'b0;
    xy_ready_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid_o) && n < 5000) begin
      step();
      n++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rand_sym();
    int nw = $urandom_range(0, 40);
    for (int i = 0; i < nw; i++) begin
      do_write($urandom_range(0, NCARRIER - 1), CONSTW'($urandom), CONSTW'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end
    do_close(1'($urandom_range(0, 1)), $urandom_range(0, NCARRIER - 1),
             CONSTW'($urandom), CONSTW'($urandom));
  endtask

  initial begin
    int n;
    int base;
    model_clear();
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_out_num", 32'(out_num_o), 32'd0);
    check("rst_out_x", 32'(out_x_o), 32'd0);
    check("rst_out_y", 32'(out_y_o), 32'd0);
    check("rst_out_last", 32'(out_last_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Sparse symbol with duplicate carrier.
    do_write(5, 15'(3), -15'sd3);
    do_write(200, -15'sd1, 15'(1));
    do_write(7, 15'(1), 15'(0));
    do_write(7, 15'(2), 15'(0));
    do_write(7, 15'(9), 15'(5));
    do_close(1'b0, 0, '0, '0);
    check("in_ready_idle_close", 32'(in_ready_o), 32'd1);
    check("latency_cycle1_valid", 32'(out_valid_o), 32'd0);
    step();
    check("latency_cycle2_valid", 32'(out_valid_o), 32'd1);
    check("latency_cycle2_num", 32'(out_num_o), 32'd0);
    wait_drain();

    // Back-to-back symbols and a dropped write.
    do_write(20, 15'(44), 15'(55));
    do_close(1'b0, 0, '0, '0);
    repeat (9) step();
    do_write(3, 15'(100), -15'sd100);
    do_close(1'b0, 0, '0, '0);
    check("in_ready_fall", 32'(in_ready_o), 32'd0);
    xy_ready_i    = 1'b1;
    carrier_num_i = CNUMW'(3);
    x_i           = 15'(77);
    y_i           = 15'(77);
    step();
    xy_ready_i = 1'b0;
    check("overflow_set", 32'(overflow_o), 32'd1);
    n = 0;
    while (!in_ready_o && n < 400) begin
      step();
      n++;
    end
    check("in_ready_rise", 32'(in_ready_o), 32'd1);
    check("in_ready_rise_at_final_hs", 32'($time - t_last_hs), 32'd6);
    check("swap_gap_valid", 32'(out_valid_o), 32'd0);
    step();
    check("second_sym_valid", 32'(out_valid_o), 32'd1);
    check("second_sym_num", 32'(out_num_o), 32'd0);
    wait_drain();

    // Randomized symbols with random backpressure, plus an empty symbol.
    rnd_ready = 1'b1;
    do_close(1'b0, 0, '0, '0);
    repeat (5) rand_sym();
    wait_drain();
    rnd_ready = 1'b0;
    step();

    // Reset mid-stream, then a fresh symbol must hold no stale data.
    check("overflow_sticky", 32'(overflow_o), 32'd1);
    for (int i = 0; i < 60; i++)
      do_write($urandom_range(0, NCARRIER - 1), CONSTW'($urandom_range(1, 1000)),
               CONSTW'($urandom_range(1, 1000)));
    do_close(1'b0, 0, '0, '0);
    for (int c = 10; c < 20; c++) do_write(c, 15'(c + 1), 15'(c + 2));
    base = beats;
    n = 0;
    while (beats - base < 100 && n < 1000) begin
      step();
      n++;
    end
    check("reached_beat_100", 32'(beats - base >= 100), 32'd1);
    reset = 1'b0;
    exp_q.delete();
    model_clear();
    #1;
    check("midrst_out_valid", 32'(out_valid_o), 32'd0);
    check("midrst_in_ready", 32'(in_ready_o), 32'd1);
    check("midrst_overflow", 32'(overflow_o), 32'd0);
    repeat (2) step();
    @(negedge clk);
    reset = 1'b1;
    step();
    do_write(50, 15'(11), -15'sd11);
    do_close(1'b0, 0, '0, '0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
